// File: rtl/paddle_timing_ctrl_pkg.sv
// Shared types and constants for the AY-3-8500 bat-position timing emulation.
package paddle_pkg;

  localparam int POS_W     = 9;
  localparam int POS_MAX   = 255;
  localparam int POS_INIT  = 128;
  localparam int STEP_SLOW = 5;
  localparam int STEP_FAST = 8;

  typedef enum logic [1:0] {
    CTRL_DIGITAL  = 2'd0,
    CTRL_ANALOG_Y = 2'd1,
    CTRL_ANALOG_X = 2'd2,
    CTRL_PADDLE   = 2'd3
  } ctrl_mode_t;

endpackage

// File: rtl/paddle_timing_ctrl_if.sv
// Player controls in, chip bat-timing pins and debug positions out.
interface paddle_timing_ctrl_if;
  import paddle_pkg::*;

  logic                    hs;
  logic                    vs;
  logic                    speed_fast;
  logic                    practice;
  ctrl_mode_t              mode_p1;
  ctrl_mode_t              mode_p2;
  logic                    invert_p1;
  logic                    invert_p2;
  logic                    up_p1;
  logic                    down_p1;
  logic                    up_p2;
  logic                    down_p2;
  logic [15:0]             analog_p1;
  logic [15:0]             analog_p2;
  logic [7:0]              paddle_p1;
  logic [7:0]              paddle_p2;
  logic                    lp_in;
  logic                    rp_in;
  logic [POS_W-1:0]        pos_p1;
  logic [POS_W-1:0]        pos_p2;

  modport master (
    output hs, vs, speed_fast, practice, mode_p1, mode_p2, invert_p1, invert_p2,
    output up_p1, down_p1, up_p2, down_p2, analog_p1, analog_p2, paddle_p1, paddle_p2,
    input  lp_in, rp_in, pos_p1, pos_p2
  );

  modport slave (
    input  hs, vs, speed_fast, practice, mode_p1, mode_p2, invert_p1, invert_p2,
    input  up_p1, down_p1, up_p2, down_p2, analog_p1, analog_p2, paddle_p1, paddle_p2,
    output lp_in, rp_in, pos_p1, pos_p2
  );

endinterface

// File: rtl/paddle_timing_ctrl_channel.sv
// One player's source select, invert, rate-limited digital position and line countdown.
module paddle_channel
  import paddle_pkg::*;
(
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i_vs_rise,
  input  logic             i_hs_rise,
  input  logic             i_speed_fast,
  input  ctrl_mode_t       i_mode,
  input  logic             i_invert,
  input  logic             i_up,
  input  logic             i_down,
  input  logic [15:0]      i_analog,
  input  logic [7:0]       i_paddle,
  output logic             o_bat,
  output logic [POS_W-1:0] o_pos
);

  typedef enum logic {ST_COUNTING, ST_FIRED} chan_state_t;

  logic [POS_W-1:0] r_cap;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_cap_nxt;
  logic [POS_W-1:0] w_pos_nxt;
  logic [POS_W-1:0] w_src;
  logic [POS_W:0]   w_step;
  logic [POS_W:0]   w_sum;
  logic [POS_W:0]   w_diff;
  chan_state_t      w_state;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cap <= '0;
      r_pos <= POS_W'(POS_INIT);
    end else begin
      r_cap <= w_cap_nxt;
      r_pos <= w_pos_nxt;
    end
  end

  always_comb begin
    w_state   = (r_cap == '0) ? ST_FIRED : ST_COUNTING;
    w_cap_nxt = r_cap;
    w_pos_nxt = r_pos;
    w_step    = i_speed_fast ? (POS_W+1)'(STEP_FAST) : (POS_W+1)'(STEP_SLOW);
    w_sum     = {1'b0, r_pos} + w_step;
    w_diff    = {1'b0, r_pos} - w_step;

    // Signed analog axes become offset binary by flipping the sign bit.
    case (i_mode)
      CTRL_DIGITAL:  w_src = r_pos;
      CTRL_ANALOG_Y: w_src = POS_W'({~i_analog[15], i_analog[14:8]});
      CTRL_ANALOG_X: w_src = POS_W'({~i_analog[7], i_analog[6:0]});
      default:       w_src = POS_W'(i_paddle);
    endcase
    if (i_invert) w_src[7:0] = ~w_src[7:0];

    if (i_vs_rise) begin
      w_cap_nxt = w_src;
      if (i_mode == CTRL_DIGITAL) begin
        if (i_down)
          w_pos_nxt = (w_sum > (POS_W+1)'(POS_MAX)) ? POS_W'(POS_MAX) : w_sum[POS_W-1:0];
        else if (i_up)
          w_pos_nxt = ({1'b0, r_pos} < w_step) ? '0 : w_diff[POS_W-1:0];
      end
    end else if (i_hs_rise && (w_state == ST_COUNTING)) begin
      w_cap_nxt = r_cap - 1'b1;
    end
  end

  assign o_bat = (w_state == ST_FIRED);
  assign o_pos = r_pos;

endmodule

// File: rtl/paddle_timing_ctrl.sv
// Sync edge detection, two paddle channels and the practice-mode mirror for LPin/RPin.
module paddle_timing_ctrl
  import paddle_pkg::*;
(
  input  logic                 clk_sys,
  input  logic                 reset,
  paddle_timing_ctrl_if.slave  bus
);

  logic r_hs_d;
  logic r_vs_d;
  logic w_hs_rise;
  logic w_vs_rise;
  logic w_lp;
  logic w_rp;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_hs_d <= bus.hs;
      r_vs_d <= bus.vs;
    end
  end

  assign w_hs_rise = bus.hs & ~r_hs_d;
  assign w_vs_rise = bus.vs & ~r_vs_d;

  paddle_channel u_ch_p1 (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i_vs_rise    (w_vs_rise),
    .i_hs_rise    (w_hs_rise),
    .i_speed_fast (bus.speed_fast),
    .i_mode       (bus.mode_p1),
    .i_invert     (bus.invert_p1),
    .i_up         (bus.up_p1),
    .i_down       (bus.down_p1),
    .i_analog     (bus.analog_p1),
    .i_paddle     (bus.paddle_p1),
    .o_bat        (w_lp),
    .o_pos        (bus.pos_p1)
  );

  paddle_channel u_ch_p2 (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i_vs_rise    (w_vs_rise),
    .i_hs_rise    (w_hs_rise),
    .i_speed_fast (bus.speed_fast),
    .i_mode       (bus.mode_p2),
    .i_invert     (bus.invert_p2),
    .i_up         (bus.up_p2),
    .i_down       (bus.down_p2),
    .i_analog     (bus.analog_p2),
    .i_paddle     (bus.paddle_p2),
    .o_bat        (w_rp),
    .o_pos        (bus.pos_p2)
  );

  assign bus.lp_in = w_lp;
  assign bus.rp_in = bus.practice ? w_lp : w_rp;

endmodule

// File: tb/tb_paddle_timing_ctrl.sv
// Directed plus randomized checks of paddle_timing_ctrl against a frame-level reference model.
module tb_paddle_timing_ctrl;
  import paddle_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int   m_cap [2];
  int   m_pos [2];
  bit   m_hsd;
  bit   m_vsd;

  paddle_timing_ctrl_if bus ();

  paddle_timing_ctrl dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // The value the chip would see for a fresh frame, from the source rules.
  function automatic int src_val(input int mode, input logic [15:0] an,
                                 input logic [7:0] pd, input int pos, input bit inv);
    int v;
    case (mode)
      0:       v = pos;
      1:       v = int'($signed(an[15:8])) + 128;
      2:       v = int'($signed(an[7:0])) + 128;
      default: v = int'(pd);
    endcase
    if (inv) v = v ^ 255;
    return v;
  endfunction

  task automatic model_ch(input int ch, input bit vr, input bit hr, input int mode,
                          input bit inv, input bit up, input bit dn,
                          input logic [15:0] an, input logic [7:0] pd);
    int step;
    step = bus.speed_fast ? 8 : 5;
    if (vr) begin
      m_cap[ch] = src_val(mode, an, pd, m_pos[ch], inv);
      if (mode == 0) begin
        if (dn)      m_pos[ch] = (m_pos[ch] + step > 255) ? 255 : m_pos[ch] + step;
        else if (up) m_pos[ch] = (m_pos[ch] < step) ? 0 : m_pos[ch] - step;
      end
    end else if (hr && m_cap[ch] > 0) begin
      m_cap[ch] = m_cap[ch] - 1;
    end
  endtask

  task automatic tick();
    bit vr;
    bit hr;
    bit exp_lp;
    bit exp_rp;
    @(posedge clk);
    if (rst) begin
      m_cap[0] = 0; m_cap[1] = 0;
      m_pos[0] = 128; m_pos[1] = 128;
      m_hsd = 0; m_vsd = 0;
    end else begin
      vr = bus.vs && !m_vsd;
      hr = bus.hs && !m_hsd;
      model_ch(0, vr, hr, int'(bus.mode_p1), bus.invert_p1, bus.up_p1, bus.down_p1,
               bus.analog_p1, bus.paddle_p1);
      model_ch(1, vr, hr, int'(bus.mode_p2), bus.invert_p2, bus.up_p2, bus.down_p2,
               bus.analog_p2, bus.paddle_p2);
      m_vsd = bus.vs;
      m_hsd = bus.hs;
    end
    #1;
    exp_lp = (m_cap[0] == 0);
    exp_rp = bus.practice ? exp_lp : (m_cap[1] == 0);
    chk("lp_in", 16'(bus.lp_in), 16'(exp_lp));
    chk("rp_in", 16'(bus.rp_in), 16'(exp_rp));
    chk("pos_p1", 16'(bus.pos_p1), 16'(m_pos[0]));
    chk("pos_p2", 16'(bus.pos_p2), 16'(m_pos[1]));
  endtask

  task automatic frame(input int nhs);
    bus.vs = 1'b1; tick();
    bus.vs = 1'b0; tick();
    repeat (nhs) begin
      bus.hs = 1'b1; tick();
      bus.hs = 1'b0; tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_cap[0] = 0; m_cap[1] = 0; m_pos[0] = 128; m_pos[1] = 128; m_hsd = 0; m_vsd = 0;
    rst = 1'b1;
    bus.hs = 0; bus.vs = 0; bus.speed_fast = 0; bus.practice = 0;
    bus.mode_p1 = CTRL_DIGITAL; bus.mode_p2 = CTRL_DIGITAL;
    bus.invert_p1 = 0; bus.invert_p2 = 0;
    bus.up_p1 = 0; bus.down_p1 = 0; bus.up_p2 = 0; bus.down_p2 = 0;
    bus.analog_p1 = '0; bus.analog_p2 = '0; bus.paddle_p1 = '0; bus.paddle_p2 = '0;

    // Reset and idle.
    do_reset();
    repeat (10) tick();
    chk("reset_lp", 16'(bus.lp_in), 16'd1);
    chk("reset_pos1", 16'(bus.pos_p1), 16'd128);

    // Full countdown of 128 lines, then further hs pulses keep it fired.
    frame(127);
    chk("count127_lp", 16'(bus.lp_in), 16'd0);
    bus.hs = 1'b1; tick(); bus.hs = 1'b0; tick();
    chk("count128_lp", 16'(bus.lp_in), 16'd1);
    repeat (5) begin bus.hs = 1'b1; tick(); bus.hs = 1'b0; tick(); end

    // Down held at slow step: saturate at 255.
    bus.down_p1 = 1'b1;
    repeat (30) frame(2);
    chk("down_sat", 16'(bus.pos_p1), 16'd255);
    bus.down_p1 = 1'b0;

    // Up held from 128 passes through 3 and clamps at 0.
    do_reset();
    bus.up_p1 = 1'b1;
    repeat (30) frame(2);
    chk("up_floor", 16'(bus.pos_p1), 16'd0);

    // Up and down together at fast step: down wins, load uses the old position.
    do_reset();
    bus.down_p1 = 1'b1; bus.speed_fast = 1'b1;
    frame(127);
    chk("both_pos", 16'(bus.pos_p1), 16'd136);
    chk("both_cap_live", 16'(bus.lp_in), 16'd0);
    bus.up_p1 = 0; bus.down_p1 = 0; bus.speed_fast = 0;

    // Analog Y conversion and invert on P2.
    bus.mode_p2 = CTRL_ANALOG_Y;
    bus.analog_p2 = 16'h8000; frame(1);
    chk("ay_min_rp", 16'(bus.rp_in), 16'd1);
    bus.analog_p2 = 16'h7F00; frame(254);
    chk("ay_max_rp", 16'(bus.rp_in), 16'd0);
    bus.invert_p2 = 1'b1; frame(1);
    chk("ay_inv_rp", 16'(bus.rp_in), 16'd1);
    bus.invert_p2 = 1'b0;

    // Load of 5, then vs and hs rising together: load wins, no decrement.
    bus.mode_p1 = CTRL_PADDLE; bus.paddle_p1 = 8'd5;
    frame(0);
    bus.paddle_p1 = 8'd20;
    bus.vs = 1'b1; bus.hs = 1'b1; tick();
    bus.vs = 1'b0; bus.hs = 1'b0; tick();
    repeat (19) begin bus.hs = 1'b1; tick(); bus.hs = 1'b0; tick(); end
    chk("vs_hs_prio_lp", 16'(bus.lp_in), 16'd0);
    bus.hs = 1'b1; tick(); bus.hs = 1'b0; tick();
    chk("vs_hs_done_lp", 16'(bus.lp_in), 16'd1);

    // Practice mirror under random P2 inputs.
    bus.practice = 1'b1;
    bus.paddle_p1 = 8'd40;
    repeat (3) begin
      bus.mode_p2 = ctrl_mode_t'($urandom_range(0, 3));
      bus.paddle_p2 = 8'($urandom);
      bus.analog_p2 = 16'($urandom);
      frame(45);
    end
    bus.practice = 1'b0;

    // Randomized traffic including mid-frame resets.
    for (int i = 0; i < 6000; i++) begin
      bus.hs = 1'($urandom_range(0, 1));
      if (bus.vs) bus.vs = ($urandom_range(0, 3) != 0);
      else        bus.vs = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 31) == 0) begin
        bus.mode_p1 = ctrl_mode_t'($urandom_range(0, 3));
        bus.mode_p2 = ctrl_mode_t'($urandom_range(0, 3));
        bus.invert_p1 = 1'($urandom); bus.invert_p2 = 1'($urandom);
        bus.up_p1 = 1'($urandom); bus.down_p1 = 1'($urandom);
        bus.up_p2 = 1'($urandom); bus.down_p2 = 1'($urandom);
        bus.speed_fast = 1'($urandom); bus.practice = ($urandom_range(0, 3) == 0);
        bus.analog_p1 = 16'($urandom); bus.analog_p2 = 16'($urandom);
        bus.paddle_p1 = 8'($urandom_range(0, 60));
        bus.paddle_p2 = 8'($urandom_range(0, 60));
      end
      rst = ($urandom_range(0, 700) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddle_timing_ctrl.md
Name: paddle_timing_ctrl

Overview:
Converts player controls into the AY-3-8500 LPin/RPin bat-position timing inputs for both players. It does this by emulating the chip's RC pot timing: at each VSYNC rising edge it latches a per-player line count, counts it down on each HSYNC rising edge, and asserts the bat input when the count reaches zero.
It also keeps the digital (keyboard/d-pad) bat position, which is rate-limited once per frame.
It sits between hps_io/keyboard decode and the chip instance, and replaces the inline paddle logic in the top level.

Parameters:
POS_W, 9, width of position/countdown registers (one guard bit above 8-bit range)
POS_MAX, 255, saturation ceiling of the digital position
POS_INIT, 128, digital position after reset
STEP_SLOW, 5, lines moved per frame when speed_fast=0
STEP_FAST, 8, lines moved per frame when speed_fast=1

Ports:
clk_sys  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
hs  in  1  horizontal sync, active-high (level; edge detected internally)
vs  in  1  vertical sync, active-high (level; edge detected internally)
speed_fast  in  1  selects STEP_FAST
practice  in  1  1: rp_in mirrors lp_in
mode_p1, mode_p2  in  2  each: 0 digital, 1 analog Y, 2 analog X, 3 paddle
invert_p1, invert_p2  in  1  each: invert the 8-bit captured value
up_p1, down_p1, up_p2, down_p2  in  1  each: digital controls, keyboard OR joystick, pre-combined
analog_p1, analog_p2  in  16  each: [15:8]=Y, [7:0]=X, signed two's complement
paddle_p1, paddle_p2  in  8  each: unsigned paddle value
lp_in  out  1  to chip pinLPin; 1 when P1 countdown = 0
rp_in  out  1  to chip pinRPin; 1 when P2 countdown = 0 (or lp_in if practice)
pos_p1, pos_p2  out  9  each: current digital position, for debug/OSD

Behaviour:
- Edge detect: hs_d/vs_d are registered copies.
  - vs_rise = vs & ~vs_d; hs_rise = hs & ~hs_d.
  - Both events act one cycle after the edge appears on the input.
- Reset:
  - pos = POS_INIT.
  - cap = 0, so lp_in = rp_in = 1 after reset.
  - hs_d = vs_d = 0.
- Per-channel FSM, two states, decoded from cap:
  - COUNTING (cap != 0): on hs_rise, cap <= cap - 1.
  - FIRED (cap == 0): hold at 0; never underflows.
- vs_rise loads cap from the selected source:
  - mode 0: cap <= pos (9 bit).
  - mode 1: cap <= {1'b0, ~analog[15], analog[14:8]}, i.e. signed Y converted to offset binary.
  - mode 2: same conversion on analog[7:0].
  - mode 3: cap <= {1'b0, paddle}.
  - Invert then XORs cap[7:0] with 8'hFF; bit 8 is untouched.
- Priority: vs_rise beats hs_rise in the same cycle; the load wins and there is no decrement.
- Digital position, updated only on vs_rise and only when mode == 0:
  - Step is STEP_FAST if speed_fast else STEP_SLOW.
  - Move is computed in POS_W+1 bits.
  - up: pos <= (pos < step) ? 0 : pos - step.
  - down: pos <= (pos + step > POS_MAX) ? POS_MAX : pos + step.
  - up & down together: down wins.
  - The cap load in the same cycle uses the pre-update pos, so the new pos is visible next frame.
- pos is held, not reset, when mode != 0.
- mode, invert or speed changes mid-frame take effect at the next vs_rise; an in-flight countdown is not disturbed.
- lp_in and rp_in are combinational from the cap registers (zero latency after the cap update).
  - practice=1: rp_in = lp_in.
- Reset asserted mid-frame: counters clear immediately (outputs go to 1) and resume at the next vs_rise after release.

Decomposition:
- Shared package paddle_pkg holds:
  - typedef ctrl_mode_t enum {CTRL_DIGITAL, CTRL_ANALOG_Y, CTRL_ANALOG_X, CTRL_PADDLE};
  - constants POS_W, POS_MAX, POS_INIT, STEP_SLOW, STEP_FAST.
- One sub-module, paddle_channel: source select, invert, digital position and countdown for one player.
- The top instantiates paddle_channel twice, and itself contains the edge detectors and the practice mux.

Test Plan:
- Reset, then idle 10 cycles -> lp_in = rp_in = 1; pos_p1 = pos_p2 = 128.
- mode_p1 = 0, no buttons, one vs_rise -> cap = 128; lp_in = 0 until the 128th hs_rise, then 1 and stays 1 through further hs pulses.
- down_p1 held, speed_fast = 0, 30 frames -> pos_p1 sequence 133, 138, … saturating at 255; with up_p1 held from 3 it goes 3 -> 0 and holds at 0.
- up_p1 & down_p1 together with speed_fast = 1 at pos 128 -> pos 136; that frame's load uses 128.
- mode_p2 = 1, analog_p2[15:8] = 8'h80 -> cap 0 (rp_in = 1 immediately); 8'h7F -> cap 255; with invert_p2, 8'h7F -> cap 0.
- vs and hs rising in the same cycle with cap = 5 -> cap = new load value, no decrement.
- practice = 1 -> rp_in tracks lp_in every cycle regardless of P2 inputs.
